// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode field layout, opcode values, and the immediate-bearing
// opcode predicate. Used by the fetch stage and the control unit.
package isa_pkg;

    localparam int unsigned OPC_W   = 5;
    localparam int unsigned INSTR_W = 16;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'h00;
    localparam logic [OPC_W-1:0] OPC_LDM  = 5'h10;
    localparam logic [OPC_W-1:0] OPC_LDD  = 5'h11;
    localparam logic [OPC_W-1:0] OPC_IADD = 5'h12;
    localparam logic [OPC_W-1:0] OPC_STD  = 5'h13;

    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    // Opcodes 1_00xx carry a second word holding a 16-bit immediate.
    function automatic logic has_imm(input logic [OPC_W-1:0] opcode);
        return opcode inside {OPC_LDM, OPC_IADD, OPC_LDD, OPC_STD};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush and reset load a bubble; hold freezes the slot.
// A non-valid slot input also loads a bubble, leaving the recorded pc untouched.
module if_id_reg
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [INSTR_W-1:0]  imm_i,
    input  logic [ADDR_W-1:0]   pc_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [INSTR_W-1:0]  imm_o,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   pc_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        instr_d = instr_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        if (flush_i || (!hold_i && !valid_i)) begin
            instr_d = NOP_WORD;
            imm_d   = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            imm_d   = imm_i;
            valid_d = 1'b1;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            imm_q   <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            instr_q <= instr_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_o = instr_q;
    assign imm_o   = imm_q;
    assign valid_o = valid_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives instruction memory, and assembles
// opcode + immediate pairs into a single IF/ID slot.
module fetch_stage
    import isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_en,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  if_instruction,
    output logic [INSTR_W-1:0]  if_immediate,
    output logic                if_valid,
    output logic [ADDR_W-1:0]   if_pc
);

    typedef enum logic [0:0] {S_FETCH, S_IMM} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;

    logic               slot_valid;
    logic [INSTR_W-1:0] slot_instr;
    logic [INSTR_W-1:0] slot_imm;
    logic [ADDR_W-1:0]  slot_pc;
    logic               word_has_imm;

    assign word_has_imm = has_imm(imem_data[INSTR_W-1 -: OPC_W]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = S_FETCH;
        end else if (!stall) begin
            unique case (state_q)
                S_FETCH: state_d = word_has_imm ? S_IMM : S_FETCH;
                S_IMM:   state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        slot_valid   = 1'b0;
        slot_instr   = NOP_WORD;
        slot_imm     = '0;
        slot_pc      = pc_q;
        if (redirect_en) begin
            pc_d         = redirect_pc;
            hold_instr_d = '0;
            hold_pc_d    = '0;
        end else if (!stall) begin
            pc_d = pc_q + ADDR_W'(1);
            unique case (state_q)
                S_FETCH: begin
                    if (word_has_imm) begin
                        hold_instr_d = imem_data;
                        hold_pc_d    = pc_q;
                    end else begin
                        slot_valid = 1'b1;
                        slot_instr = imem_data;
                    end
                end
                S_IMM: begin
                    // The word at pc is the immediate; it is never decoded.
                    slot_valid = 1'b1;
                    slot_instr = hold_instr_q;
                    slot_imm   = imem_data;
                    slot_pc    = hold_pc_q;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .hold_i  (stall),
        .flush_i (redirect_en),
        .valid_i (slot_valid),
        .instr_i (slot_instr),
        .imm_i   (slot_imm),
        .pc_i    (slot_pc),
        .instr_o (if_instruction),
        .imm_o   (if_immediate),
        .valid_o (if_valid),
        .pc_o    (if_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 16-bit and a 4-bit address instance share control inputs;
// a behavioural model is checked every cycle, plus literal checks on directed scenarios.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = '0;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:15];

    logic [15:0] a_addr, a_data, a_instr, a_imm, a_pc;
    logic        a_valid;
    logic [3:0]  b_addr, b_pc;
    logic [15:0] b_data, b_instr, b_imm;
    logic        b_valid;

    assign a_data = mem_a[a_addr[7:0]];
    assign b_data = mem_b[b_addr];

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut_a (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .imem_addr      (a_addr),
        .imem_data      (a_data),
        .if_instruction (a_instr),
        .if_immediate   (a_imm),
        .if_valid       (a_valid),
        .if_pc          (a_pc)
    );

    fetch_stage #(.ADDR_W(4), .RESET_PC(4'h0)) u_dut_b (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc[3:0]),
        .imem_addr      (b_addr),
        .imem_data      (b_data),
        .if_instruction (b_instr),
        .if_immediate   (b_imm),
        .if_valid       (b_valid),
        .if_pc          (b_pc)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = 16-bit instance, 1 = 4-bit instance.
    logic [15:0] m_pc [2];
    logic        m_pend [2];
    logic [15:0] m_hi [2];
    logic [15:0] m_hpc [2];
    logic [15:0] m_in [2];
    logic [15:0] m_im [2];
    logic        m_val [2];
    logic [15:0] m_ipc [2];
    logic        m_live = 1'b0;

    function automatic logic [15:0] fetch_word(input int k, input logic [15:0] a);
        return (k == 0) ? mem_a[a[7:0]] : mem_b[a[3:0]];
    endfunction

    task automatic model_step(input int k);
        logic [15:0] mask, w;
        int op;
        mask = (k == 0) ? 16'hFFFF : 16'h000F;
        if (reset) begin
            m_pc[k] = 0; m_pend[k] = 0;
            m_in[k] = 0; m_im[k] = 0; m_val[k] = 0; m_ipc[k] = 0;
        end else if (redirect_en) begin
            m_pc[k] = redirect_pc & mask; m_pend[k] = 0;
            m_in[k] = 0; m_im[k] = 0; m_val[k] = 0;
        end else if (!stall) begin
            w  = fetch_word(k, m_pc[k]);
            op = int'(w >> 11);
            if (m_pend[k]) begin
                m_in[k] = m_hi[k]; m_im[k] = w; m_val[k] = 1; m_ipc[k] = m_hpc[k];
                m_pend[k] = 0;
            end else if (op >= 16 && op <= 19) begin
                m_hi[k] = w; m_hpc[k] = m_pc[k]; m_pend[k] = 1;
                m_in[k] = 0; m_im[k] = 0; m_val[k] = 0;
            end else begin
                m_in[k] = w; m_im[k] = 0; m_val[k] = 1; m_ipc[k] = m_pc[k];
            end
            m_pc[k] = (m_pc[k] + 16'd1) & mask;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        m_live = 1'b1;
        #1;
        chk("a.addr",  a_addr,  m_pc[0]);
        chk("a.instr", a_instr, m_in[0]);
        chk("a.imm",   a_imm,   m_im[0]);
        chk("a.valid", {15'd0, a_valid}, {15'd0, m_val[0]});
        chk("a.pc",    a_pc,    m_ipc[0]);
        chk("b.addr",  {12'd0, b_addr}, m_pc[1]);
        chk("b.instr", b_instr, m_in[1]);
        chk("b.imm",   b_imm,   m_im[1]);
        chk("b.valid", {15'd0, b_valid}, {15'd0, m_val[1]});
        chk("b.pc",    {12'd0, b_pc}, m_ipc[1]);
    end

    task automatic cyc(input logic r, input logic s, input logic re, input logic [15:0] rp);
        @(negedge clk);
        reset = r; stall = s; redirect_en = re; redirect_pc = rp;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = {5'd3, 11'(i)};
        for (int i = 0; i < 16; i++)  mem_b[i] = {5'd4, 11'(i)};
        mem_a[0] = 16'h0800; mem_a[1] = 16'h9000; mem_a[2] = 16'h0005; mem_a[3] = 16'h1000;
        mem_a[4] = 16'h8100; mem_a[5] = 16'h00FF; mem_a[6] = 16'h2800; mem_a[7] = 16'h3000;
        mem_a[8] = 16'h9800; mem_a[9] = 16'h0042;
        mem_a[32] = 16'h8900; mem_a[33] = 16'hABCD;
        mem_a[255] = 16'h8000;
        mem_b[0] = 16'h1234; mem_b[15] = 16'h8800;

        // Reset for two cycles.
        cyc(1, 0, 0, 0);
        chk("rst.valid", {15'd0, a_valid}, 16'd0);
        chk("rst.instr", a_instr, 16'h0000);
        chk("rst.addr",  a_addr, 16'h0000);
        cyc(1, 0, 0, 0);
        // One-word, two-word, one-word back to back.
        cyc(0, 0, 0, 0);
        chk("rel.instr", a_instr, 16'h0800);
        chk("rel.pc",    a_pc, 16'h0000);
        chk("b2b.v0",    {15'd0, a_valid}, 16'd1);
        cyc(0, 0, 0, 0);
        chk("b2b.v1",    {15'd0, a_valid}, 16'd0);
        cyc(0, 0, 0, 0);
        chk("b2b.v2",    {15'd0, a_valid}, 16'd1);
        chk("b2b.instr", a_instr, 16'h9000);
        chk("b2b.imm",   a_imm, 16'h0005);
        chk("b2b.pc2",   a_pc, 16'h0001);
        cyc(0, 0, 0, 0);
        chk("b2b.v3",    {15'd0, a_valid}, 16'd1);
        chk("b2b.pc3",   a_pc, 16'h0003);
        // LDM at 4: one bubble, then assembled slot.
        cyc(0, 0, 0, 0);
        chk("ldm.bub",   {15'd0, a_valid}, 16'd0);
        chk("ldm.addr",  a_addr, 16'h0005);
        cyc(0, 0, 0, 0);
        chk("ldm.instr", a_instr, 16'h8100);
        chk("ldm.imm",   a_imm, 16'h00FF);
        chk("ldm.pc",    a_pc, 16'h0004);
        chk("ldm.next",  a_addr, 16'h0006);
        cyc(0, 0, 0, 0);
        // Three stall cycles hold everything.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("stl.addr",  a_addr, 16'h0007);
            chk("stl.instr", a_instr, 16'h2800);
            chk("stl.valid", {15'd0, a_valid}, 16'd1);
            chk("stl.pc",    a_pc, 16'h0006);
        end
        cyc(0, 0, 0, 0);
        chk("res.instr", a_instr, 16'h3000);
        chk("res.pc",    a_pc, 16'h0007);
        // STD at 8 held, stalled, then redirect with stall drops it.
        cyc(0, 0, 0, 0);
        chk("std.bub",   {15'd0, a_valid}, 16'd0);
        cyc(0, 1, 0, 0);
        chk("std.addr",  a_addr, 16'h0009);
        cyc(0, 1, 1, 16'h0020);
        chk("rdr.addr",  a_addr, 16'h0020);
        chk("rdr.valid", {15'd0, a_valid}, 16'd0);
        cyc(0, 0, 0, 0);
        chk("rdr.bub",   {15'd0, a_valid}, 16'd0);
        cyc(0, 0, 0, 0);
        chk("rdr.instr", a_instr, 16'h8900);
        chk("rdr.imm",   a_imm, 16'hABCD);
        chk("rdr.pc",    a_pc, 16'h0020);
        // Wrap in the 4-bit instance: LDD at 15, immediate from 0.
        cyc(0, 0, 1, 16'h000F);
        chk("wrp.addr0", {12'd0, b_addr}, 16'h000F);
        cyc(0, 0, 0, 0);
        chk("wrp.bub",   {15'd0, b_valid}, 16'd0);
        cyc(0, 0, 0, 0);
        chk("wrp.instr", b_instr, 16'h8800);
        chk("wrp.imm",   b_imm, 16'h1234);
        chk("wrp.pc",    {12'd0, b_pc}, 16'h000F);
        chk("wrp.addr",  {12'd0, b_addr}, 16'h0001);
        // Wrap in the 16-bit instance at 0xFFFF.
        cyc(0, 0, 1, 16'hFFFF);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("w16.instr", a_instr, 16'h8000);
        chk("w16.imm",   a_imm, 16'h0800);
        chk("w16.pc",    a_pc, 16'hFFFF);
        chk("w16.addr",  a_addr, 16'h0001);
        // Reset overrides stall and redirect.
        cyc(1, 1, 1, 16'h0040);
        chk("rov.addr",  a_addr, 16'h0000);
        chk("rov.valid", {15'd0, a_valid}, 16'd0);
        chk("rov.pc",    a_pc, 16'h0000);
        cyc(0, 0, 0, 0);
        chk("rov.instr", a_instr, 16'h0800);
        // Mixed stream with periodic stalls; the model covers these.
        for (int i = 0; i < 24; i++) cyc(0, (i % 3) == 1, 0, 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
